// File: rtl/sdram_arbiter.sv
// Two-master round-robin arbiter for the native SDRAM bus port. Every transaction
// is followed by a one-cycle release gap, and a watchdog aborts hung transactions.
module sdram_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ABORT_RDATA    = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        s0_valid,
    input  logic [3:0]  s0_wen,
    input  logic [23:0] s0_addr,
    input  logic [31:0] s0_wdata,
    output logic [31:0] s0_rdata,
    output logic        s0_ready,

    input  logic        s1_valid,
    input  logic [3:0]  s1_wen,
    input  logic [23:0] s1_addr,
    input  logic [31:0] s1_wdata,
    output logic [31:0] s1_rdata,
    output logic        s1_ready,

    output logic        m_valid,
    output logic [3:0]  m_wen,
    output logic [23:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ready,

    output logic [1:0]  grant,
    input  logic        err_clr,
    output logic        timeout_err
);

    localparam int CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam bit               WDOG_EN   = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_ABORT   = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_owner;
    logic             r_last;
    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout_err;

    logic             w_req_any;
    logic             w_pick;
    logic             w_own_valid;
    logic             w_limit;
    logic [1:0]       w_own_onehot;

    assign w_req_any    = s0_valid | s1_valid;
    // On a tie the master that did not win last time gets the port.
    assign w_pick       = (s0_valid & s1_valid) ? ~r_last : s1_valid;
    assign w_own_valid  = r_owner ? s1_valid : s0_valid;
    assign w_limit      = WDOG_EN && (r_cnt == CNT_LIMIT);
    assign w_own_onehot = r_owner ? 2'b10 : 2'b01;
    assign timeout_err  = r_timeout_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_req_any) begin
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // m_ready beats both a dropped valid and the watchdog limit.
                if (m_ready) begin
                    w_state_nxt = ST_RELEASE;
                end else if (!w_own_valid) begin
                    w_state_nxt = ST_RELEASE;
                end else if (w_limit) begin
                    w_state_nxt = ST_ABORT;
                end
            end
            ST_ABORT:   w_state_nxt = ST_RELEASE;
            ST_RELEASE: w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner       <= 1'b0;
            r_last        <= 1'b1;
            r_cnt         <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && w_req_any) begin
                r_owner <= w_pick;
                r_last  <= w_pick;
                r_cnt   <= '0;
            end else if (r_state == ST_BUSY && r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (r_state == ST_ABORT) begin
                r_timeout_err <= 1'b1;
            end else if (err_clr) begin
                r_timeout_err <= 1'b0;
            end
        end
    end

    always_comb begin
        m_valid  = 1'b0;
        m_wen    = '0;
        m_addr   = '0;
        m_wdata  = '0;
        grant    = '0;
        s0_ready = 1'b0;
        s1_ready = 1'b0;
        s0_rdata = m_rdata;
        s1_rdata = m_rdata;
        case (r_state)
            ST_BUSY: begin
                grant    = w_own_onehot;
                m_valid  = w_own_valid;
                m_wen    = r_owner ? s1_wen   : s0_wen;
                m_addr   = r_owner ? s1_addr  : s0_addr;
                m_wdata  = r_owner ? s1_wdata : s0_wdata;
                s0_ready = ~r_owner & m_ready;
                s1_ready = r_owner & m_ready;
            end
            ST_ABORT: begin
                grant    = w_own_onehot;
                s0_ready = ~r_owner;
                s1_ready = r_owner;
                if (r_owner) begin
                    s1_rdata = ABORT_RDATA;
                end else begin
                    s0_rdata = ABORT_RDATA;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: a transaction-level model checked every cycle,
// plus hand-computed expectations for latency, fairness, watchdog and error flag.
module tb_sdram_arbiter;

    localparam int          TO        = 8;
    localparam logic [31:0] ABORT_VAL = 32'hDEADBEEF;
    localparam int          PH_IDLE   = 0;
    localparam int          PH_BUSY   = 1;
    localparam int          PH_ABORT  = 2;
    localparam int          PH_GAP    = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        s0_valid, s1_valid;
    logic [3:0]  s0_wen, s1_wen;
    logic [23:0] s0_addr, s1_addr;
    logic [31:0] s0_wdata, s1_wdata;
    logic [31:0] s0_rdata, s1_rdata;
    logic        s0_ready, s1_ready;
    logic        m_valid;
    logic [3:0]  m_wen;
    logic [23:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata = 32'h0;
    logic        m_ready = 1'b0;
    logic [1:0]  grant;
    logic        err_clr;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sdram_arbiter #(.TIMEOUT_CYCLES(TO), .ABORT_RDATA(ABORT_VAL)) dut (
        .clk(clk), .reset(reset),
        .s0_valid(s0_valid), .s0_wen(s0_wen), .s0_addr(s0_addr), .s0_wdata(s0_wdata),
        .s0_rdata(s0_rdata), .s0_ready(s0_ready),
        .s1_valid(s1_valid), .s1_wen(s1_wen), .s1_addr(s1_addr), .s1_wdata(s1_wdata),
        .s1_rdata(s1_rdata), .s1_ready(s1_ready),
        .m_valid(m_valid), .m_wen(m_wen), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ready(m_ready),
        .grant(grant), .err_clr(err_clr), .timeout_err(timeout_err)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic look();
        @(negedge clk);
        #1;
    endtask

    task automatic drive_cyc();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level model: who holds the bus, for how long, and whether it is aborting.
    int md_phase = PH_IDLE;
    int md_own   = 0;
    int md_last  = 1;
    int md_age   = 0;
    bit md_err   = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            md_phase = PH_IDLE;
            md_own   = 0;
            md_last  = 1;
            md_age   = 0;
            md_err   = 1'b0;
        end else begin
            if (md_phase == PH_ABORT) md_err = 1'b1;
            else if (err_clr)         md_err = 1'b0;
            case (md_phase)
                PH_IDLE: begin
                    if (s0_valid || s1_valid) begin
                        if (s0_valid && s1_valid) md_own = 1 - md_last;
                        else                      md_own = s1_valid ? 1 : 0;
                        md_last  = md_own;
                        md_age   = 0;
                        md_phase = PH_BUSY;
                    end
                end
                PH_BUSY: begin
                    if (m_ready)                                      md_phase = PH_GAP;
                    else if (!(md_own == 1 ? s1_valid : s0_valid))    md_phase = PH_GAP;
                    else if (md_age == TO)                            md_phase = PH_ABORT;
                    if (md_age < 1000000) md_age++;
                end
                PH_ABORT: md_phase = PH_GAP;
                default:  md_phase = PH_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        logic        on_bus, busy, own1, ov;
        logic [1:0]  eg;
        logic [3:0]  ewen;
        logic [23:0] eaddr;
        logic [31:0] ewdata, er0d, er1d;
        logic        er0, er1;
        busy   = (md_phase == PH_BUSY);
        on_bus = busy || (md_phase == PH_ABORT);
        own1   = (md_own == 1);
        ov     = own1 ? s1_valid : s0_valid;
        eg     = on_bus ? (own1 ? 2'b10 : 2'b01) : 2'b00;
        ewen   = busy ? (own1 ? s1_wen : s0_wen) : 4'h0;
        eaddr  = busy ? (own1 ? s1_addr : s0_addr) : 24'h0;
        ewdata = busy ? (own1 ? s1_wdata : s0_wdata) : 32'h0;
        er0    = (md_phase == PH_ABORT && !own1) || (busy && !own1 && m_ready);
        er1    = (md_phase == PH_ABORT && own1) || (busy && own1 && m_ready);
        er0d   = (md_phase == PH_ABORT && !own1) ? ABORT_VAL : m_rdata;
        er1d   = (md_phase == PH_ABORT && own1) ? ABORT_VAL : m_rdata;
        check("model_grant",   64'(grant),       64'(eg));
        check("model_m_valid", 64'(m_valid),     64'(busy && ov));
        check("model_m_wen",   64'(m_wen),       64'(ewen));
        check("model_m_addr",  64'(m_addr),      64'(eaddr));
        check("model_m_wdata", 64'(m_wdata),     64'(ewdata));
        check("model_s0_ready",64'(s0_ready),    64'(er0));
        check("model_s1_ready",64'(s1_ready),    64'(er1));
        check("model_s0_rdata",64'(s0_rdata),    64'(er0d));
        check("model_s1_rdata",64'(s1_rdata),    64'(er1d));
        check("model_terr",    64'(timeout_err), 64'(md_err));
    end

    // Ready pulse counters and a log of each new grant with the bus contents at that time.
    typedef struct {
        logic [1:0]  g;
        logic [3:0]  wen;
        logic [23:0] addr;
    } gnt_t;
    gnt_t       glog[$];
    logic [1:0] prev_g = 2'b00;
    int         r0_cnt = 0;
    int         r1_cnt = 0;

    always @(negedge clk) begin
        if (s0_ready) r0_cnt++;
        if (s1_ready) r1_cnt++;
        if (grant != 2'b00 && prev_g == 2'b00) glog.push_back('{grant, m_wen, m_addr});
        prev_g = grant;
    end

    // Bridge stand-in: answers after br_lat cycles of m_valid; 0 means never.
    int          br_lat  = 0;
    int          br_cnt  = 0;
    logic [31:0] br_data = 32'h0;

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (m_ready) begin
                m_ready = 1'b0;
                m_rdata = 32'h0;
                br_cnt  = 0;
            end else if (m_valid) begin
                br_cnt++;
                if (br_lat > 0 && br_cnt == br_lat) begin
                    m_ready = 1'b1;
                    m_rdata = br_data;
                end
            end else begin
                br_cnt = 0;
            end
        end
    end

    task automatic wait_grant(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            look();
            if (grant != 2'b00) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Called in the grant cycle; idx counts cycles after it.
    task automatic wait_ready(input int m, input int lim, output int idx, output logic [31:0] d);
        idx = -1;
        d   = 32'h0;
        for (int i = 1; i <= lim; i++) begin
            look();
            if (m == 0 ? s0_ready : s1_ready) begin
                idx = i;
                d   = (m == 0) ? s0_rdata : s1_rdata;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int          idx;
        logic [31:0] d;
        int          b0, b1;
        bit          ok;

        reset = 1'b1; err_clr = 1'b0;
        s0_valid = 1'b0; s0_wen = 4'h0; s0_addr = 24'h0; s0_wdata = 32'h0;
        s1_valid = 1'b0; s1_wen = 4'h0; s1_addr = 24'h0; s1_wdata = 32'h0;
        repeat (3) look();
        check("rst_grant",   64'(grant),       64'(0));
        check("rst_m_valid", 64'(m_valid),     64'(0));
        check("rst_terr",    64'(timeout_err), 64'(0));
        drive_cyc(); reset = 1'b0;
        look();
        check("idle_grant", 64'(grant), 64'(0));

        // Single read from master 0
        br_lat = 4; br_data = 32'h12345678; b0 = r0_cnt; b1 = r1_cnt;
        drive_cyc(); s0_valid = 1'b1; s0_wen = 4'h0; s0_addr = 24'h000100;
        look();
        check("rd_lat_before", 64'(m_valid), 64'(0));
        look();
        check("rd_lat_after",  64'(m_valid), 64'(1));
        check("rd_grant",      64'(grant),   64'(2'b01));
        check("rd_addr",       64'(m_addr),  64'(24'h000100));
        wait_ready(0, 20, idx, d);
        check("rd_ready_cycle", 64'(idx), 64'(3));
        check("rd_data",        64'(d),   64'(32'h12345678));
        drive_cyc(); s0_valid = 1'b0;
        look();
        check("rd_gap_m_valid", 64'(m_valid),       64'(0));
        check("rd_s0_pulses",   64'(r0_cnt - b0),   64'(1));
        check("rd_s1_pulses",   64'(r1_cnt - b1),   64'(0));

        // Contention from reset, then reset in the middle of a transaction
        drive_cyc(); reset = 1'b1;
        s0_valid = 1'b1; s0_wen = 4'h0; s0_addr = 24'h000200;
        s1_valid = 1'b1; s1_wen = 4'b0011; s1_addr = 24'h0000F0; s1_wdata = 32'h55AA55AA;
        br_lat = 2; br_data = 32'h0BADF00D;
        glog.delete();
        drive_cyc(); reset = 1'b0;
        for (int i = 0; i < 40 && glog.size() < 4; i++) look();
        check("ct_grants_seen", 64'(glog.size() >= 4), 64'(1));
        for (int k = 0; k < 4 && k < glog.size(); k++) begin
            check("ct_grant_seq", 64'(glog[k].g), 64'((k % 2 == 0) ? 2'b01 : 2'b10));
            if (k % 2 == 1) begin
                check("ct_s1_wen",  64'(glog[k].wen),  64'(4'b0011));
                check("ct_s1_addr", 64'(glog[k].addr), 64'(24'h0000F0));
            end else begin
                check("ct_s0_addr", 64'(glog[k].addr), 64'(24'h000200));
            end
        end
        for (int i = 0; i < 10 && !m_valid; i++) look();
        check("rst_mid_busy_seen", 64'(m_valid), 64'(1));
        reset = 1'b1;
        #1;
        check("rst_mid_grant",   64'(grant),    64'(0));
        check("rst_mid_m_valid", 64'(m_valid),  64'(0));
        check("rst_mid_s0_rdy",  64'(s0_ready), 64'(0));
        check("rst_mid_s1_rdy",  64'(s1_ready), 64'(0));
        s0_valid = 1'b0; s0_addr = 24'h0;
        s1_valid = 1'b0; s1_wen = 4'h0; s1_addr = 24'h0; s1_wdata = 32'h0;
        drive_cyc(); reset = 1'b0;
        look();
        check("rst_post_grant", 64'(grant),       64'(0));
        check("rst_post_terr",  64'(timeout_err), 64'(0));

        // Watchdog abort on master 1
        br_lat = 0; b0 = r0_cnt;
        drive_cyc(); s1_valid = 1'b1; s1_wen = 4'h0; s1_addr = 24'h000400;
        wait_grant(5, ok);
        check("wd_grant", 64'(grant), 64'(2'b10));
        wait_ready(1, 15, idx, d);
        check("wd_ready_cycle", 64'(idx),        64'(9));
        check("wd_abort_data",  64'(d),          64'(32'hDEADBEEF));
        check("wd_m_valid",     64'(m_valid),    64'(0));
        check("wd_s0_pulses",   64'(r0_cnt - b0), 64'(0));
        drive_cyc(); s1_valid = 1'b0;
        look();
        check("wd_terr_set", 64'(timeout_err), 64'(1));
        repeat (4) look();
        check("wd_terr_sticky", 64'(timeout_err), 64'(1));
        drive_cyc(); err_clr = 1'b1;
        drive_cyc(); err_clr = 1'b0;
        look();
        check("wd_terr_clr", 64'(timeout_err), 64'(0));

        // m_ready on the exact limit cycle completes normally
        br_lat = 9; br_data = 32'hCAFEF00D; b0 = r0_cnt;
        drive_cyc(); s0_valid = 1'b1; s0_addr = 24'h000500;
        wait_grant(5, ok);
        check("bd_grant", 64'(grant), 64'(2'b01));
        wait_ready(0, 15, idx, d);
        check("bd_ready_cycle", 64'(idx), 64'(8));
        check("bd_data",        64'(d),   64'(32'hCAFEF00D));
        drive_cyc(); s0_valid = 1'b0;
        look();
        check("bd_terr",      64'(timeout_err),  64'(0));
        check("bd_s0_pulses", 64'(r0_cnt - b0),  64'(1));

        // err_clr in the abort cycle: set wins
        br_lat = 0;
        drive_cyc(); s1_valid = 1'b1; s1_addr = 24'h000600;
        wait_grant(5, ok);
        wait_ready(1, 15, idx, d);
        check("ec_ready_cycle", 64'(idx), 64'(9));
        err_clr = 1'b1;
        drive_cyc(); err_clr = 1'b0; s1_valid = 1'b0;
        look();
        check("ec_set_wins", 64'(timeout_err), 64'(1));
        drive_cyc(); err_clr = 1'b1;
        drive_cyc(); err_clr = 1'b0;
        look();
        check("ec_cleared", 64'(timeout_err), 64'(0));

        // Master 0 drops valid mid-transaction; late master 1 request waits its turn
        br_lat = 0; b0 = r0_cnt;
        drive_cyc(); s0_valid = 1'b1; s0_addr = 24'h000700;
        wait_grant(5, ok);
        check("vd_grant0", 64'(grant), 64'(2'b01));
        drive_cyc(); s1_valid = 1'b1; s1_addr = 24'h000800;
        look();
        check("vd_no_preempt", 64'(grant), 64'(2'b01));
        drive_cyc(); s0_valid = 1'b0; br_lat = 3; br_data = 32'hFEEDFACE;
        look();
        check("vd_drop_s0_rdy",  64'(s0_ready), 64'(0));
        check("vd_drop_m_valid", 64'(m_valid),  64'(0));
        wait_grant(10, ok);
        check("vd_grant1", 64'(grant), 64'(2'b10));
        wait_ready(1, 10, idx, d);
        check("vd_s1_cycle", 64'(idx), 64'(2));
        check("vd_s1_data",  64'(d),   64'(32'hFEEDFACE));
        drive_cyc(); s1_valid = 1'b0;
        check("vd_s0_pulses", 64'(r0_cnt - b0), 64'(0));
        repeat (2) look();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Two-master round-robin arbiter that shares the single SDRAM native-bus port (valid/wen/addr/wdata/rdata/ready, 24-bit address) between the CPU memory interface (master 0) and a secondary requester such as DMA or video fetch (master 1). It sits directly upstream of the native-to-Avalon SDRAM bridge. Each transaction is delivered to the bridge as a clean valid pulse separated by at least one idle cycle, because the bridge tracks read state across cycles. A bus watchdog aborts hung transactions.

## Interface
- TIMEOUT_CYCLES, default 1024: maximum number of busy cycles before the transaction is aborted; 0 disables the watchdog.
- ABORT_RDATA, default 32'hDEADBEEF: read data returned to the master on an aborted transaction.
- clk  in  1  system clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-high reset.
- s0_valid, s1_valid  in  1 each  master request, held until that master's ready.
- s0_wen, s1_wen  in  4 each  byte write enables; 0 means read.
- s0_addr, s1_addr  in  24 each  byte address.
- s0_wdata, s1_wdata  in  32 each  write data.
- s0_rdata, s1_rdata  out  32 each  read data, valid only while the matching ready is high.
- s0_ready, s1_ready  out  1 each  transaction complete.
- m_valid  out  1  request to the SDRAM bridge.
- m_wen  out  4  forwarded write enables.
- m_addr  out  24  forwarded address.
- m_wdata  out  32  forwarded write data.
- m_rdata  in  32  bridge read data.
- m_ready  in  1  bridge completion.
- grant  out  2  one-hot current owner (bit0 = master 0); 0 when no master owns the port.
- err_clr  in  1  synchronous clear of timeout_err.
- timeout_err  out  1  sticky flag, set when a watchdog abort occurs.

## Operation
- **States:** IDLE, BUSY, ABORT, RELEASE.
- **Registers:** state, owner, last (the last granted master), watchdog counter, timeout_err.
- **IDLE:**
  - If exactly one sN_valid is high, that master becomes owner.
  - If both are high, the owner is the master that is not `last`.
  - On grant, go to BUSY and set last = owner.
- **BUSY:**
  - m_valid, m_wen, m_addr and m_wdata are the owner's inputs, muxed combinationally.
  - The owner's ready equals m_ready; the owner's rdata equals m_rdata.
- **BUSY transitions:**
  - m_ready high: go to RELEASE.
  - Owner's valid drops before ready (protocol violation): go to RELEASE with no ready pulse.
  - Counter reaches TIMEOUT_CYCLES (when nonzero) with m_ready low: go to ABORT.
- **ABORT:**
  - m_valid = 0.
  - Owner's ready = 1 for exactly one cycle, with rdata = ABORT_RDATA.
  - Set timeout_err, then go to RELEASE.
- **RELEASE:** m_valid = 0, grant = 0, no readies. After one cycle, go to IDLE.
- **Non-owner isolation:** a non-owner's ready is always 0. In every state except BUSY and ABORT, both readies are 0.
- **Read data:** sN_rdata equals m_rdata whenever that master is not in ABORT; only ready qualifies it.
- **Outputs outside BUSY:** m_wen, m_addr and m_wdata are forced to 0.
- **Watchdog counter:**
  - Clears on entry to BUSY and increments each BUSY cycle.
  - Its width is clog2(TIMEOUT_CYCLES+1) and it saturates; it never wraps.
- **timeout_err:**
  - err_clr clears it.
  - If err_clr and an abort occur in the same cycle, set wins.

## Timing
- **Reset values:** state = IDLE, last = 1 (so master 0 wins the first tie), counter = 0, timeout_err = 0. All outputs are 0 during and after reset.
- **Reset mid-transaction:** immediate return to IDLE. No ready is issued, and m_valid drops asynchronously.
- **Grant latency:** a request sampled high in IDLE at edge N gives m_valid high in the cycle after edge N.
- **Ready path:** m_ready to sN_ready is combinational, zero-cycle.
- **Back-to-back spacing:** minimum of 3 cycles between consecutive transactions, since RELEASE always separates them.
- **Fairness:** with both masters continuously requesting, grants strictly alternate 0,1,0,1.
- **Late request:** a request arriving during BUSY or RELEASE waits until IDLE and does not preempt the current owner.
- **m_ready outside BUSY:** ignored.
- **Watchdog boundary:** the abort fires on the edge where the counter equals TIMEOUT_CYCLES. When m_ready arrives in the same cycle the limit is hit, m_ready takes priority and the transaction completes normally.

## Test plan
- **Reset:** assert reset mid-BUSY -> grant = 0, m_valid = 0 at once; after release, state is IDLE and timeout_err = 0.
- **Single read:** s0 reads addr 24'h000100; bridge returns 32'h12345678 with m_ready after 4 cycles -> s0_ready pulses once with s0_rdata = 32'h12345678, s1_ready stays 0, m_valid is low for at least 1 cycle afterward.
- **Contention:** both masters request continuously from reset, with an s1 write of wen = 4'b0011 to 24'h0000F0 -> grant sequence 01, 10, 01, 10; m_wen = 4'b0011 and m_addr = 24'h0000F0 during master 1's turns.
- **Watchdog:** TIMEOUT_CYCLES = 8, m_ready never asserts -> s1_ready pulses on the 9th cycle after grant with s1_rdata = 32'hDEADBEEF, timeout_err = 1, and it stays 1 until err_clr.
- **Boundary:** m_ready arrives on the exact limit cycle -> normal completion with bridge data and timeout_err = 0. Separately, err_clr and an abort in the same cycle -> timeout_err = 1.
- **Valid drop:** master 0 drops valid in BUSY before ready -> RELEASE, no s0_ready pulse, master 1 granted next if requesting.
